sm3_pad: RTL and testbench

SM3_PAD -- requirements
Module: sm3_pad

---
 rtl/sm3_pad.sv | 181 ++++++++++++++++++
 tb/tb_sm3_pad.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sm3_pad.sv
// SM3 message padder: packs 32-bit message words into 512-bit blocks and
// appends the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sm3_pad (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {IDLE, FILL, OUT, OUTF} state_t;

  state_t      state_r, state_nxt;
  logic [31:0] blk_buf_r   [16];
  logic [31:0] blk_buf_nxt [16];
  logic [3:0]  w_r, w_nxt, w_inc_s;
  logic [63:0] len_r, len_nxt, len_last_s;
  logic        pad_pend_r, pad_pend_nxt;
  logic        owe_r, owe_nxt;
  logic        first_r, first_nxt;
  logic        msg_ready_r, blk_valid_r, blk_first_r, blk_last_r;
  logic [2:0]  n_s;
  logic [6:0]  b_s;
  logic        acc_s, take_s;

  function automatic logic [2:0] clamp_nbytes(input logic [2:0] nb);
    clamp_nbytes = (nb > 3'd4) ? 3'd4 : nb;
  endfunction

  // Keep the first n bytes of the final word; the marker goes right after them.
  function automatic logic [31:0] last_word(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {d[31:24], 24'h80_0000};
      3'd2:    last_word = {d[31:16], 16'h8000};
      3'd3:    last_word = {d[31:8], 8'h80};
      3'd4:    last_word = d;
      default: last_word = d;
    endcase
  endfunction

  assign n_s        = clamp_nbytes(msg_nbytes);
  assign b_s        = {1'b0, w_r, 2'b00} + {4'd0, n_s};
  assign w_inc_s    = w_r + 4'd1;
  assign len_last_s = len_r + {58'd0, n_s, 3'd0};
  assign acc_s      = msg_valid & msg_ready_r;
  assign take_s     = blk_valid_r & blk_ready;

  // Next-state, buffer construction and length bookkeeping.
  always_comb begin
    state_nxt    = state_r;
    blk_buf_nxt  = blk_buf_r;
    w_nxt        = w_r;
    len_nxt      = len_r;
    pad_pend_nxt = pad_pend_r;
    owe_nxt      = owe_r;
    first_nxt    = first_r;
    case (state_r)
      IDLE: begin
        state_nxt = FILL;
      end
      FILL: begin
        if (acc_s && msg_last) begin
          len_nxt = len_last_s;
          for (int i = 0; i < 16; i++) begin
            if (4'(i) == w_r) begin
              blk_buf_nxt[i] = last_word(msg_data, n_s);
            end else if (4'(i) == w_inc_s && n_s == 3'd4 && w_r != 4'd15) begin
              blk_buf_nxt[i] = 32'h8000_0000;
            end else if (4'(i) > w_r) begin
              blk_buf_nxt[i] = 32'h0000_0000;
            end else begin
              blk_buf_nxt[i] = blk_buf_r[i];
            end
          end
          if (b_s <= 7'd55) begin
            blk_buf_nxt[14] = len_last_s[63:32];
            blk_buf_nxt[15] = len_last_s[31:0];
            state_nxt       = OUTF;
          end else begin
            pad_pend_nxt = 1'b1;
            owe_nxt      = (b_s == 7'd64);
            state_nxt    = OUT;
          end
        end else if (acc_s) begin
          blk_buf_nxt[w_r] = msg_data;
          len_nxt          = len_r + 64'd32;
          w_nxt            = w_inc_s;
          state_nxt        = (w_r == 4'd15) ? OUT : FILL;
        end else begin
          state_nxt = FILL;
        end
      end
      OUT: begin
        if (take_s && pad_pend_r) begin
          for (int i = 0; i < 16; i++) begin
            blk_buf_nxt[i] = 32'h0000_0000;
          end
          blk_buf_nxt[0]  = owe_r ? 32'h8000_0000 : 32'h0000_0000;
          blk_buf_nxt[14] = len_r[63:32];
          blk_buf_nxt[15] = len_r[31:0];
          first_nxt       = 1'b0;
          state_nxt       = OUTF;
        end else if (take_s) begin
          first_nxt = 1'b0;
          w_nxt     = 4'd0;
          state_nxt = FILL;
        end else begin
          state_nxt = OUT;
        end
      end
      OUTF: begin
        if (take_s) begin
          len_nxt      = 64'd0;
          pad_pend_nxt = 1'b0;
          owe_nxt      = 1'b0;
          w_nxt        = 4'd0;
          first_nxt    = 1'b1;
          state_nxt    = FILL;
        end else begin
          state_nxt = OUTF;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, buffer and registered handshake/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      w_r         <= 4'd0;
      len_r       <= 64'd0;
      pad_pend_r  <= 1'b0;
      owe_r       <= 1'b0;
      first_r     <= 1'b1;
      msg_ready_r <= 1'b0;
      blk_valid_r <= 1'b0;
      blk_first_r <= 1'b0;
      blk_last_r  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        blk_buf_r[i] <= 32'h0000_0000;
      end
    end else begin
      state_r     <= state_nxt;
      w_r         <= w_nxt;
      len_r       <= len_nxt;
      pad_pend_r  <= pad_pend_nxt;
      owe_r       <= owe_nxt;
      first_r     <= first_nxt;
      blk_buf_r   <= blk_buf_nxt;
      msg_ready_r <= (state_nxt == FILL);
      blk_valid_r <= (state_nxt == OUT) || (state_nxt == OUTF);
      blk_last_r  <= (state_nxt == OUTF);
      blk_first_r <= ((state_nxt == OUT) || (state_nxt == OUTF)) && first_nxt;
    end
  end

  // Flatten the buffer, word 0 in the most significant position.
  always_comb begin
    blk_data = 512'd0;
    for (int i = 0; i < 16; i++) begin
      blk_data[511 - 32*i -: 32] = blk_buf_r[i];
    end
  end

  assign msg_ready = msg_ready_r;
  assign blk_valid = blk_valid_r;
  assign blk_first = blk_first_r;
  assign blk_last  = blk_last_r;

endmodule

// File: tb/tb_sm3_pad.sv
// Directed self-checking bench for sm3_pad with hand-computed padded blocks.
module tb_sm3_pad;

  logic         clk;
  logic         rst_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  msg_data;
  logic         msg_last;
  logic [2:0]   msg_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [511:0] exp_blk;

  sm3_pad dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .msg_last   (msg_last),
    .msg_nbytes (msg_nbytes),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_first  (blk_first),
    .blk_last   (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int k;
    msg_valid  = 1'b1;
    msg_data   = d;
    msg_last   = last;
    msg_nbytes = nb;
    k = 0;
    while (!msg_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!msg_ready) chk("msg_ready_wait", {511'd0, msg_ready}, 512'd1);
    @(posedge clk); #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic take_block(input string tag, input logic [511:0] exp, input logic ef, input logic el);
    int k;
    k = 0;
    while (!blk_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_valid"}, {511'd0, blk_valid}, 512'd1);
    chk({tag, "_data"}, blk_data, exp);
    chk({tag, "_first"}, {511'd0, blk_first}, {511'd0, ef});
    chk({tag, "_last"}, {511'd0, blk_last}, {511'd0, el});
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    msg_valid  = 1'b0;
    msg_data   = 32'd0;
    msg_last   = 1'b0;
    msg_nbytes = 3'd0;
    blk_ready  = 1'b0;
    #12;
    chk("rst_msg_ready", {511'd0, msg_ready}, 512'd0);
    chk("rst_blk_valid", {511'd0, blk_valid}, 512'd0);
    chk("rst_blk_first", {511'd0, blk_first}, 512'd0);
    chk("rst_blk_last",  {511'd0, blk_last},  512'd0);
    chk("rst_blk_data",  blk_data, 512'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc"
    send_word(32'h6162_6300, 1'b1, 3'd3);
    chk("abc_latency", {511'd0, blk_valid}, 512'd1);
    take_block("abc", {32'h6162_6380, 416'd0, 32'h0, 32'h18}, 1'b1, 1'b1);

    // Empty message
    send_word(32'hFFFF_FFFF, 1'b1, 3'd0);
    take_block("empty", {32'h8000_0000, 480'd0}, 1'b1, 1'b1);

    // Two words, last has 2 valid bytes: 6 bytes = 48 bits
    send_word(32'h1122_3344, 1'b0, 3'd0);
    send_word(32'hAABB_CCDD, 1'b1, 3'd2);
    take_block("mask", {32'h1122_3344, 32'hAABB_8000, 384'd0, 32'h0, 32'h30}, 1'b1, 1'b1);

    // nbytes=7 is treated as 4: marker lands in word 1, length 32
    send_word(32'hDEAD_BEEF, 1'b1, 3'd7);
    take_block("nb7", {32'hDEAD_BEEF, 32'h8000_0000, 384'd0, 32'h0, 32'h20}, 1'b1, 1'b1);

    // 55 bytes: still fits in one block, length 440 = 0x1B8
    for (int i = 0; i < 13; i++) send_word(32'hA500_0000 + 32'(i), 1'b0, 3'd0);
    send_word(32'hA500_000D, 1'b1, 3'd3);
    exp_blk = 512'd0;
    for (int i = 0; i < 13; i++) exp_blk[511 - 32*i -: 32] = 32'hA500_0000 + 32'(i);
    exp_blk[511 - 32*13 -: 32] = 32'hA500_0080;
    exp_blk[31:0] = 32'h0000_01B8;
    take_block("b55", exp_blk, 1'b1, 1'b1);

    // 56 bytes: two blocks, with backpressure on the first
    for (int i = 0; i < 13; i++) send_word(32'hA500_0000 + 32'(i), 1'b0, 3'd0);
    send_word(32'hA500_000D, 1'b1, 3'd4);
    exp_blk = 512'd0;
    for (int i = 0; i < 14; i++) exp_blk[511 - 32*i -: 32] = 32'hA500_0000 + 32'(i);
    exp_blk[511 - 32*14 -: 32] = 32'h8000_0000;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", {511'd0, blk_valid}, 512'd1);
      chk("bp_data", blk_data, exp_blk);
      chk("bp_msg_ready", {511'd0, msg_ready}, 512'd0);
      @(posedge clk); #1;
    end
    take_block("b56_1", exp_blk, 1'b1, 1'b0);
    chk("b56_extra_latency", {511'd0, blk_valid}, 512'd1);
    take_block("b56_2", {480'd0, 32'h0000_01C0}, 1'b0, 1'b1);

    // 64 bytes: pure data block then marker+length block
    for (int i = 0; i < 15; i++) send_word(32'hC300_0000 + 32'(i), 1'b0, 3'd0);
    send_word(32'hC300_000F, 1'b1, 3'd4);
    exp_blk = 512'd0;
    for (int i = 0; i < 16; i++) exp_blk[511 - 32*i -: 32] = 32'hC300_0000 + 32'(i);
    take_block("b64_1", exp_blk, 1'b1, 1'b0);
    chk("b64_extra_latency", {511'd0, blk_valid}, 512'd1);
    take_block("b64_2", {32'h8000_0000, 416'd0, 32'h0, 32'h200}, 1'b0, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    take_block("after64", {32'h6162_6380, 416'd0, 32'h0, 32'h18}, 1'b1, 1'b1);

    // Reset in the middle of a message
    for (int i = 0; i < 3; i++) send_word(32'h7777_0000 + 32'(i), 1'b0, 3'd0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_msg_ready", {511'd0, msg_ready}, 512'd0);
    chk("mid_rst_blk_valid", {511'd0, blk_valid}, 512'd0);
    chk("mid_rst_blk_first", {511'd0, blk_first}, 512'd0);
    chk("mid_rst_blk_last",  {511'd0, blk_last},  512'd0);
    chk("mid_rst_blk_data",  blk_data, 512'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    take_block("post_rst", {32'h6162_6380, 416'd0, 32'h0, 32'h18}, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
